// File: rtl/lab7_pkg.sv
// Shared lab 7 memory definitions: ram32x4 geometry and the scan reader state encoding.
package lab7_pkg;

  localparam int unsigned RAM_DEPTH  = 32;
  localparam int unsigned RAM_ADDR_W = 5;
  localparam int unsigned RAM_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } scan_state_t;

endpackage

// File: rtl/rate_divider.sv
// Down-counter that pulses tick for one cycle, TICK_COUNT-1 cycles after load.
module rate_divider #(
  parameter int unsigned TICK_COUNT = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_COUNT > 2) ? $clog2(TICK_COUNT) : 1;

  logic [CNT_W-1:0] count;

  // tick is registered, so it rises in the cycle the count reaches zero
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (load) begin
      count <= CNT_W'(TICK_COUNT - 1);
      tick  <= 1'b0;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
      tick  <= (count == CNT_W'(1));
    end else begin
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_scan_reader.sv
// Read-side scanner for ram32x4: walks addresses at a programmable rate or per step
// pulse, yielding the RAM port to the writer whenever wr_busy is high.
module ram_scan_reader
  import lab7_pkg::*;
#(
  parameter int unsigned TICK_COUNT = 50_000_000,
  parameter int unsigned ADDR_W     = RAM_ADDR_W,
  parameter int unsigned DATA_W     = RAM_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              step,
  input  logic              wr_busy,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              port_owned,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  scan_state_t       state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
  logic              single, single_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt, disp_addr_nxt;
  logic [DATA_W-1:0] disp_data_nxt;
  logic              port_owned_nxt, disp_valid_nxt, wrap_nxt;
  logic              load_c;
  logic              tick;

  rate_divider #(
    .TICK_COUNT(TICK_COUNT)
  ) u_rate_divider (
    .clock(clock),
    .reset(reset),
    .load (load_c),
    .tick (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable || step) state_nxt = ISSUE;
      ISSUE:   if (!wr_busy) state_nxt = CAPTURE;
      CAPTURE: state_nxt = single ? IDLE : HOLD;
      HOLD:    if (tick) state_nxt = enable ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the datapath; port ownership drops by default outside ISSUE/CAPTURE
  always_comb begin
    cur_addr_nxt   = cur_addr;
    single_nxt     = single;
    ram_addr_nxt   = ram_addr;
    disp_addr_nxt  = disp_addr;
    disp_data_nxt  = disp_data;
    disp_valid_nxt = disp_valid;
    port_owned_nxt = 1'b0;
    wrap_nxt       = 1'b0;
    load_c         = 1'b0;
    case (state)
      IDLE: begin
        if (enable)    single_nxt = 1'b0;
        else if (step) single_nxt = 1'b1;
      end
      ISSUE: begin
        if (!wr_busy) begin
          ram_addr_nxt   = cur_addr;
          port_owned_nxt = 1'b1;
        end
      end
      CAPTURE: begin
        disp_data_nxt  = ram_q;
        disp_addr_nxt  = cur_addr;
        disp_valid_nxt = 1'b1;
        cur_addr_nxt   = (cur_addr == LAST_ADDR) ? '0 : cur_addr + ADDR_W'(1);
        wrap_nxt       = (cur_addr == LAST_ADDR);
        load_c         = !single;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_addr   <= '0;
      single     <= 1'b0;
      ram_addr   <= '0;
      port_owned <= 1'b0;
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      cur_addr   <= cur_addr_nxt;
      single     <= single_nxt;
      ram_addr   <= ram_addr_nxt;
      port_owned <= port_owned_nxt;
      disp_addr  <= disp_addr_nxt;
      disp_data  <= disp_data_nxt;
      disp_valid <= disp_valid_nxt;
      wrap       <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader with TICK_COUNT=4 and a RAM holding address mod 16.
module tb_ram_scan_reader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       step = 1'b0;
  logic       wr_busy = 1'b0;
  logic [3:0] ram_q;
  logic [4:0] ram_addr;
  logic       port_owned;
  logic [4:0] disp_addr;
  logic [3:0] disp_data;
  logic       disp_valid;
  logic       wrap;

  logic [3:0] mem [32];
  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  assign ram_q = mem[ram_addr];

  ram_scan_reader #(.TICK_COUNT(4), .ADDR_W(5), .DATA_W(4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .step(step), .wr_busy(wr_busy),
    .ram_q(ram_q), .ram_addr(ram_addr), .port_owned(port_owned), .disp_addr(disp_addr),
    .disp_data(disp_data), .disp_valid(disp_valid), .wrap(wrap)
  );

  task automatic clk();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) clk();
    checks++; if (ram_addr !== 5'd0) begin fails++; $display("FAIL reset_ram_addr: got %0d expected 0", ram_addr); end
    checks++; if (port_owned !== 1'b0) begin fails++; $display("FAIL reset_port_owned: got %0b expected 0", port_owned); end
    checks++; if (disp_addr !== 5'd0) begin fails++; $display("FAIL reset_disp_addr: got %0d expected 0", disp_addr); end
    checks++; if (disp_data !== 4'd0) begin fails++; $display("FAIL reset_disp_data: got %0d expected 0", disp_data); end
    checks++; if (disp_valid !== 1'b0) begin fails++; $display("FAIL reset_disp_valid: got %0b expected 0", disp_valid); end
    checks++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
  endtask

  task automatic test_run_scan();
    reset = 1'b0;
    enable = 1'b1;
    clk();
    checks++; if (port_owned !== 1'b0) begin fails++; $display("FAIL run_issue_owned: got %0b expected 0", port_owned); end
    clk();
    checks++; if (port_owned !== 1'b1) begin fails++; $display("FAIL run_capture_owned: got %0b expected 1", port_owned); end
    checks++; if (ram_addr !== 5'd0) begin fails++; $display("FAIL run_ram_addr0: got %0d expected 0", ram_addr); end
    checks++; if (disp_valid !== 1'b0) begin fails++; $display("FAIL run_valid_early: got %0b expected 0", disp_valid); end
    clk();
    checks++; if (disp_valid !== 1'b1) begin fails++; $display("FAIL run_valid: got %0b expected 1", disp_valid); end
    checks++; if (disp_addr !== 5'd0 || disp_data !== 4'd0) begin fails++; $display("FAIL run_word0: got %0d/%0d expected 0/0", disp_addr, disp_data); end
    checks++; if (port_owned !== 1'b0) begin fails++; $display("FAIL run_hold_owned: got %0b expected 0", port_owned); end
    for (int k = 1; k <= 3; k++) begin
      repeat (5) clk();
      checks++; if (disp_addr !== 5'(k - 1)) begin fails++; $display("FAIL run_hold_addr%0d: got %0d expected %0d", k, disp_addr, k - 1); end
      clk();
      checks++; if (disp_addr !== 5'(k) || disp_data !== 4'(k)) begin fails++; $display("FAIL run_word%0d: got %0d/%0d expected %0d/%0d", k, disp_addr, disp_data, k, k); end
    end
  endtask

  task automatic test_wr_busy();
    repeat (4) clk();
    checks++; if (port_owned !== 1'b0 || disp_addr !== 5'd3) begin fails++; $display("FAIL busy_entry: got owned=%0b addr=%0d expected 0/3", port_owned, disp_addr); end
    wr_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk();
      checks++; if (port_owned !== 1'b0 || disp_addr !== 5'd3) begin fails++; $display("FAIL busy_stall%0d: got owned=%0b addr=%0d expected 0/3", i, port_owned, disp_addr); end
    end
    wr_busy = 1'b0;
    clk();
    checks++; if (port_owned !== 1'b1 || ram_addr !== 5'd4) begin fails++; $display("FAIL busy_issue: got owned=%0b addr=%0d expected 1/4", port_owned, ram_addr); end
    wr_busy = 1'b1;
    clk();
    wr_busy = 1'b0;
    checks++; if (disp_addr !== 5'd4 || disp_data !== 4'd4) begin fails++; $display("FAIL busy_capture: got %0d/%0d expected 4/4", disp_addr, disp_data); end
  endtask

  task automatic test_wrap();
    repeat (6 * 26) clk();
    checks++; if (disp_addr !== 5'd30 || wrap !== 1'b0) begin fails++; $display("FAIL wrap_pre: got addr=%0d wrap=%0b expected 30/0", disp_addr, wrap); end
    repeat (6) clk();
    checks++; if (disp_addr !== 5'd31 || disp_data !== 4'd15) begin fails++; $display("FAIL wrap_word31: got %0d/%0d expected 31/15", disp_addr, disp_data); end
    checks++; if (wrap !== 1'b1) begin fails++; $display("FAIL wrap_pulse: got %0b expected 1", wrap); end
    clk();
    checks++; if (wrap !== 1'b0) begin fails++; $display("FAIL wrap_pulse_end: got %0b expected 0", wrap); end
    repeat (5) clk();
    checks++; if (disp_addr !== 5'd0 || disp_data !== 4'd0 || wrap !== 1'b0) begin fails++; $display("FAIL wrap_word0: got %0d/%0d wrap=%0b expected 0/0/0", disp_addr, disp_data, wrap); end
  endtask

  task automatic test_enable_drop();
    repeat (6) clk();
    checks++; if (disp_addr !== 5'd1 || disp_data !== 4'd1) begin fails++; $display("FAIL drop_word1: got %0d/%0d expected 1/1", disp_addr, disp_data); end
    clk();
    enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      clk();
      checks++; if (port_owned !== 1'b0 || ram_addr !== 5'd1 || disp_addr !== 5'd1 || disp_data !== 4'd1) begin
        fails++; $display("FAIL drop_idle%0d: got owned=%0b ram=%0d disp=%0d/%0d expected 0/1/1/1", i, port_owned, ram_addr, disp_addr, disp_data);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    reset = 1'b1;
    clk();
    reset = 1'b0;
    enable = 1'b1;
    repeat (3) clk();
    repeat (42) clk();
    checks++; if (disp_addr !== 5'd7 || disp_data !== 4'd7) begin fails++; $display("FAIL rst_word7: got %0d/%0d expected 7/7", disp_addr, disp_data); end
    clk();
    reset = 1'b1;
    enable = 1'b0;
    clk();
    checks++; if (ram_addr !== 5'd0 || port_owned !== 1'b0 || disp_addr !== 5'd0 || disp_data !== 4'd0 || disp_valid !== 1'b0 || wrap !== 1'b0) begin
      fails++; $display("FAIL rst_mid_hold: got ram=%0d owned=%0b disp=%0d/%0d valid=%0b wrap=%0b expected all 0", ram_addr, port_owned, disp_addr, disp_data, disp_valid, wrap);
    end
    reset = 1'b0;
    enable = 1'b1;
    clk();
    clk();
    checks++; if (port_owned !== 1'b1 || ram_addr !== 5'd0) begin fails++; $display("FAIL rst_restart_issue: got owned=%0b addr=%0d expected 1/0", port_owned, ram_addr); end
    clk();
    checks++; if (disp_addr !== 5'd0 || disp_valid !== 1'b1) begin fails++; $display("FAIL rst_restart_word: got addr=%0d valid=%0b expected 0/1", disp_addr, disp_valid); end
    enable = 1'b0;
    repeat (6) clk();
  endtask

  task automatic test_step();
    reset = 1'b1;
    clk();
    reset = 1'b0;
    step = 1'b1;
    clk();
    step = 1'b0;
    checks++; if (port_owned !== 1'b0) begin fails++; $display("FAIL step1_issue: got %0b expected 0", port_owned); end
    clk();
    checks++; if (port_owned !== 1'b1 || ram_addr !== 5'd0) begin fails++; $display("FAIL step1_capture: got owned=%0b addr=%0d expected 1/0", port_owned, ram_addr); end
    step = 1'b1;
    clk();
    step = 1'b0;
    checks++; if (disp_addr !== 5'd0 || disp_valid !== 1'b1 || port_owned !== 1'b0) begin fails++; $display("FAIL step1_word: got addr=%0d valid=%0b owned=%0b expected 0/1/0", disp_addr, disp_valid, port_owned); end
    for (int i = 0; i < 8; i++) begin
      clk();
      checks++; if (port_owned !== 1'b0 || disp_addr !== 5'd0) begin fails++; $display("FAIL step1_idle%0d: got owned=%0b addr=%0d expected 0/0", i, port_owned, disp_addr); end
    end
    step = 1'b1;
    clk();
    step = 1'b0;
    checks++; if (port_owned !== 1'b0) begin fails++; $display("FAIL step2_issue: got %0b expected 0", port_owned); end
    clk();
    checks++; if (port_owned !== 1'b1 || ram_addr !== 5'd1) begin fails++; $display("FAIL step2_capture: got owned=%0b addr=%0d expected 1/1", port_owned, ram_addr); end
    clk();
    checks++; if (disp_addr !== 5'd1 || disp_data !== 4'd1 || port_owned !== 1'b0) begin fails++; $display("FAIL step2_word: got %0d/%0d owned=%0b expected 1/1/0", disp_addr, disp_data, port_owned); end
    for (int i = 0; i < 4; i++) begin
      clk();
      checks++; if (port_owned !== 1'b0 || disp_addr !== 5'd1) begin fails++; $display("FAIL step2_idle%0d: got owned=%0b addr=%0d expected 0/1", i, port_owned, disp_addr); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 4'(i % 16);
    test_reset();
    test_run_scan();
    test_wr_busy();
    test_wrap();
    test_enable_drop();
    test_reset_mid_hold();
    test_step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
